// File: rtl/instr_encoder_writer.sv
// ---------------------------------------------------------------------------
// instr_encoder_writer
//
// Boot-time program loader. It takes one abstract instruction per handshake
// (operation code plus rd/rs1/rs2/imm fields), turns it into RV32I machine
// code and writes the words one after another into instruction memory. The
// pseudo-instruction LI expands into a LUI/ADDI pair, so it writes two words.
//
// Parameters
//   ADDR_W     byte-address width of the imem write port
//   BASE_ADDR  byte address of the first word after reset or addr_clr
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   in_valid     instruction fields valid
//   in_ready     encoder can accept (high only while idle)
//   in_op        operation: 0 LW,1 SW,2 ADD,3 SUB,4 AND,5 OR,6 SLT,7 ADDI,
//                8 ANDI,9 ORI,10 SLTI,11 BEQ,12 BNE,13 BLT,14 BGE,15 JAL,
//                16 JALR,17 LUI,18 LI; 19-31 are illegal
//   in_rd        destination register
//   in_rs1       source register 1
//   in_rs2       source register 2
//   in_imm       immediate (byte offset, LUI upper bits in [19:0], LI value)
//   addr_clr     reload the write address with BASE_ADDR
//   imem_we      one-cycle write strobe per word
//   imem_addr    byte address of the word being written
//   imem_wdata   encoded instruction word
//   err          one-cycle pulse when an illegal op is accepted
//   word_cnt     number of words written since reset (wraps)
// ---------------------------------------------------------------------------
module instr_encoder_writer #(
   parameter int          ADDR_W    = 12,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        in_op,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [31:0]       in_imm,
   input  logic              addr_clr,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              err,
   output logic [15:0]       word_cnt
);

   // Abstract operation codes accepted on in_op.
   localparam logic [4:0] OP_LW   = 5'd0;
   localparam logic [4:0] OP_SW   = 5'd1;
   localparam logic [4:0] OP_ADD  = 5'd2;
   localparam logic [4:0] OP_SUB  = 5'd3;
   localparam logic [4:0] OP_AND  = 5'd4;
   localparam logic [4:0] OP_OR   = 5'd5;
   localparam logic [4:0] OP_SLT  = 5'd6;
   localparam logic [4:0] OP_ADDI = 5'd7;
   localparam logic [4:0] OP_ANDI = 5'd8;
   localparam logic [4:0] OP_ORI  = 5'd9;
   localparam logic [4:0] OP_SLTI = 5'd10;
   localparam logic [4:0] OP_BEQ  = 5'd11;
   localparam logic [4:0] OP_BNE  = 5'd12;
   localparam logic [4:0] OP_BLT  = 5'd13;
   localparam logic [4:0] OP_BGE  = 5'd14;
   localparam logic [4:0] OP_JAL  = 5'd15;
   localparam logic [4:0] OP_JALR = 5'd16;
   localparam logic [4:0] OP_LUI  = 5'd17;
   localparam logic [4:0] OP_LI   = 5'd18;

   // RV32I major opcodes.
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_REG    = 7'b0110011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   // The base address is forced word-aligned so imem_addr[1:0] can never
   // pick up stray low bits from a misconfigured parameter.
   localparam logic [ADDR_W-1:0] L_BASE_RAW = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] L_BASE     = {L_BASE_RAW[ADDR_W-1:2], 2'b00};
   localparam logic [ADDR_W-1:0] L_STEP     = ADDR_W'(4);

   typedef enum logic [1:0] {
      IDLE,
      EMIT,
      EMIT_LO
   } stateT;

   stateT             r_state;
   logic [31:0]       r_loWord;
   logic              r_isLi;
   logic [ADDR_W-1:0] r_addr;
   logic [15:0]       r_wordCnt;
   logic              r_we;
   logic [31:0]       r_wdata;
   logic              r_err;

   logic              w_legal;
   logic [31:0]       w_firstWord;
   logic [31:0]       w_liLoWord;

   // Build the first (or only) machine word for an operation. For LI this is
   // the LUI half; the +0x800 pre-compensates for the sign extension that the
   // following ADDI applies to its low 12 bits.
   function automatic logic [31:0] encodeWord(
      input logic [4:0]  op,
      input logic [4:0]  rd,
      input logic [4:0]  rs1,
      input logic [4:0]  rs2,
      input logic [31:0] imm
   );
      logic [31:0] liHi;
      liHi = imm + 32'h0000_0800;
      case (op)
         OP_LW:   encodeWord = {imm[11:0], rs1, 3'b010, rd, OPC_LOAD};
         OP_SW:   encodeWord = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_STORE};
         OP_ADD:  encodeWord = {7'b0000000, rs2, rs1, 3'b000, rd, OPC_REG};
         OP_SUB:  encodeWord = {7'b0100000, rs2, rs1, 3'b000, rd, OPC_REG};
         OP_AND:  encodeWord = {7'b0000000, rs2, rs1, 3'b111, rd, OPC_REG};
         OP_OR:   encodeWord = {7'b0000000, rs2, rs1, 3'b110, rd, OPC_REG};
         OP_SLT:  encodeWord = {7'b0000000, rs2, rs1, 3'b010, rd, OPC_REG};
         OP_ADDI: encodeWord = {imm[11:0], rs1, 3'b000, rd, OPC_IMM};
         OP_ANDI: encodeWord = {imm[11:0], rs1, 3'b111, rd, OPC_IMM};
         OP_ORI:  encodeWord = {imm[11:0], rs1, 3'b110, rd, OPC_IMM};
         OP_SLTI: encodeWord = {imm[11:0], rs1, 3'b010, rd, OPC_IMM};
         OP_BEQ:  encodeWord = {imm[12], imm[10:5], rs2, rs1, 3'b000,
                                imm[4:1], imm[11], OPC_BRANCH};
         OP_BNE:  encodeWord = {imm[12], imm[10:5], rs2, rs1, 3'b001,
                                imm[4:1], imm[11], OPC_BRANCH};
         OP_BLT:  encodeWord = {imm[12], imm[10:5], rs2, rs1, 3'b100,
                                imm[4:1], imm[11], OPC_BRANCH};
         OP_BGE:  encodeWord = {imm[12], imm[10:5], rs2, rs1, 3'b101,
                                imm[4:1], imm[11], OPC_BRANCH};
         OP_JAL:  encodeWord = {imm[20], imm[10:1], imm[11], imm[19:12],
                                rd, OPC_JAL};
         OP_JALR: encodeWord = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
         OP_LUI:  encodeWord = {imm[19:0], rd, OPC_LUI};
         OP_LI:   encodeWord = {liHi[31:12], rd, OPC_LUI};
         default: encodeWord = 32'h0000_0000;
      endcase
   endfunction

   // Decode legality and precompute both words while the fields are still on
   // the input bus, so the FSM only has to capture results at the accept edge.
   always_comb begin
      w_legal     = (in_op <= OP_LI);
      w_firstWord = encodeWord(in_op, in_rd, in_rs1, in_rs2, in_imm);
      w_liLoWord  = {in_imm[11:0], in_rd, 3'b000, in_rd, OPC_IMM};
   end

   // Main sequencer. Every output is a register updated here. The write
   // strobe for a word is raised at the edge that enters its write cycle, so
   // imem_we/imem_wdata line up with the current address register. A clear
   // request always wins over the post-write increment, which means a word
   // being written during the clear still lands at the old address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_loWord  <= 32'h0000_0000;
         r_isLi    <= 1'b0;
         r_addr    <= L_BASE;
         r_wordCnt <= 16'h0000;
         r_we      <= 1'b0;
         r_wdata   <= 32'h0000_0000;
         r_err     <= 1'b0;
      end else begin
         r_we  <= 1'b0;
         r_err <= 1'b0;

         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  if (w_legal) begin
                     r_we     <= 1'b1;
                     r_wdata  <= w_firstWord;
                     r_loWord <= w_liLoWord;
                     r_isLi   <= (in_op == OP_LI);
                     r_state  <= EMIT;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            EMIT: begin
               if (r_isLi) begin
                  r_we    <= 1'b1;
                  r_wdata <= r_loWord;
                  r_state <= EMIT_LO;
               end else begin
                  r_state <= IDLE;
               end
            end
            EMIT_LO: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase

         if (r_we) begin
            r_wordCnt <= r_wordCnt + 16'd1;
         end

         if (addr_clr) begin
            r_addr <= L_BASE;
         end else if (r_we) begin
            r_addr <= r_addr + L_STEP;
         end
      end
   end

   assign in_ready   = (r_state == IDLE);
   assign imem_we    = r_we;
   assign imem_addr  = r_addr;
   assign imem_wdata = r_wdata;
   assign err        = r_err;
   assign word_cnt   = r_wordCnt;

endmodule

// File: tb/tb_instr_encoder_writer.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder_writer
//
// Drives directed instructions from the loader's intended use (plain ops,
// LI expansion, illegal ops, address wrap, clear and reset in mid-flight)
// followed by random instructions, and compares each write against a
// reference built from the RV32I field layout with plain arithmetic.
// A 4-bit address port is used so the wrap happens after four words.
// ---------------------------------------------------------------------------
module tb_instr_encoder_writer;

   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic [4:0]    in_op = '0;
   logic [4:0]    in_rd = '0;
   logic [4:0]    in_rs1 = '0;
   logic [4:0]    in_rs2 = '0;
   logic [31:0]   in_imm = '0;
   logic          addr_clr = 1'b0;
   logic          in_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          err;
   logic [15:0]   word_cnt;

   int passCount = 0;
   int checkCount = 0;
   int modelAddr = 0;
   int modelCnt = 0;

   instr_encoder_writer #(
      .ADDR_W   (AW),
      .BASE_ADDR(0)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_rd     (in_rd),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .in_imm    (in_imm),
      .addr_clr  (addr_clr),
      .imem_we   (imem_we),
      .imem_addr (imem_addr),
      .imem_wdata(imem_wdata),
      .err       (err),
      .word_cnt  (word_cnt)
   );

   always #5 clk = ~clk;

   // Hard stop in case the sequence ever stalls.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Field-packing helpers for the reference model.
   function automatic logic [31:0] packI(logic [31:0] opc, logic [31:0] f3,
                                         logic [4:0] rd, logic [4:0] rs1,
                                         logic [31:0] imm);
      return ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (f3 << 12)
             | (32'(rd) << 7) | opc;
   endfunction

   function automatic logic [31:0] packR(logic [31:0] f7, logic [31:0] f3,
                                         logic [4:0] rd, logic [4:0] rs1,
                                         logic [4:0] rs2);
      return (f7 << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (f3 << 12)
             | (32'(rd) << 7) | 32'h33;
   endfunction

   function automatic logic [31:0] packB(logic [31:0] f3, logic [4:0] rs1,
                                         logic [4:0] rs2, logic [31:0] imm);
      return (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
             | (32'(rs2) << 20) | (32'(rs1) << 15) | (f3 << 12)
             | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7)
             | 32'h63;
   endfunction

   // Reference for the first (or only) word of an operation.
   function automatic logic [31:0] refWord(logic [4:0] op, logic [4:0] rd,
                                           logic [4:0] rs1, logic [4:0] rs2,
                                           logic [31:0] imm);
      logic [31:0] liVal;
      case (int'(op))
         0:  return packI(32'h03, 2, rd, rs1, imm);
         1:  return (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20)
                    | (32'(rs1) << 15) | (32'd2 << 12)
                    | ((imm & 32'h1F) << 7) | 32'h23;
         2:  return packR(0, 0, rd, rs1, rs2);
         3:  return packR(32, 0, rd, rs1, rs2);
         4:  return packR(0, 7, rd, rs1, rs2);
         5:  return packR(0, 6, rd, rs1, rs2);
         6:  return packR(0, 2, rd, rs1, rs2);
         7:  return packI(32'h13, 0, rd, rs1, imm);
         8:  return packI(32'h13, 7, rd, rs1, imm);
         9:  return packI(32'h13, 6, rd, rs1, imm);
         10: return packI(32'h13, 2, rd, rs1, imm);
         11: return packB(0, rs1, rs2, imm);
         12: return packB(1, rs1, rs2, imm);
         13: return packB(4, rs1, rs2, imm);
         14: return packB(5, rs1, rs2, imm);
         15: return (((imm >> 20) & 32'h1) << 31)
                    | (((imm >> 1) & 32'h3FF) << 21)
                    | (((imm >> 11) & 32'h1) << 20)
                    | (((imm >> 12) & 32'hFF) << 12)
                    | (32'(rd) << 7) | 32'h6F;
         16: return packI(32'h67, 0, rd, rs1, imm);
         17: return ((imm & 32'hFFFFF) << 12) | (32'(rd) << 7) | 32'h37;
         18: begin
            liVal = imm + 32'd2048;
            return ((liVal >> 12) << 12) | (32'(rd) << 7) | 32'h37;
         end
         default: return 32'h0;
      endcase
   endfunction

   // Second word of LI: ADDI rd, rd, low 12 bits.
   function automatic logic [31:0] refLiLow(logic [4:0] rd, logic [31:0] imm);
      return packI(32'h13, 0, rd, rd, imm);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
   endtask

   task automatic modelWrite();
      modelAddr = (modelAddr + 4) % (1 << AW);
      modelCnt  = (modelCnt + 1) % 65536;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("resetWe", 32'(imem_we), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      modelAddr = 0;
      modelCnt  = 0;
   endtask

   // Present one instruction and let it be accepted at the next rising edge;
   // returns #1 after that edge (inside the first write cycle).
   task automatic acceptInstr(input logic [4:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm);
      @(negedge clk);
      in_valid = 1'b1;
      in_op    = op;
      in_rd    = rd;
      in_rs1   = rs1;
      in_rs2   = rs2;
      in_imm   = imm;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_op    = 5'd31;
      in_imm   = $urandom;
   endtask

   // Full transaction with checks of every cycle until the loader is idle.
   task automatic applyStimulus(input logic [4:0] op, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm,
                                output logic [31:0] obs1,
                                output logic [31:0] obs2);
      obs1 = 32'h0;
      obs2 = 32'h0;
      acceptInstr(op, rd, rs1, rs2, imm);
      if (int'(op) > 18) begin
         checkOutput("illegalErr",   32'(err),       32'd1);
         checkOutput("illegalWe",    32'(imem_we),   32'd0);
         checkOutput("illegalReady", 32'(in_ready),  32'd1);
         checkOutput("illegalAddr",  32'(imem_addr), 32'(modelAddr));
         checkOutput("illegalCnt",   32'(word_cnt),  32'(modelCnt));
         @(posedge clk);
         #1;
         checkOutput("errOneCycle",  32'(err),       32'd0);
         checkOutput("illegalWe2",   32'(imem_we),   32'd0);
      end else begin
         checkOutput("word1We",    32'(imem_we),   32'd1);
         checkOutput("word1Addr",  32'(imem_addr), 32'(modelAddr));
         checkOutput("word1Data",  imem_wdata,     refWord(op, rd, rs1, rs2, imm));
         checkOutput("word1Ready", 32'(in_ready),  32'd0);
         obs1 = imem_wdata;
         modelWrite();
         @(posedge clk);
         #1;
         if (int'(op) == 18) begin
            checkOutput("word2We",    32'(imem_we),   32'd1);
            checkOutput("word2Addr",  32'(imem_addr), 32'(modelAddr));
            checkOutput("word2Data",  imem_wdata,     refLiLow(rd, imm));
            checkOutput("word2Ready", 32'(in_ready),  32'd0);
            obs2 = imem_wdata;
            modelWrite();
            @(posedge clk);
            #1;
         end
         checkOutput("doneWe",    32'(imem_we),   32'd0);
         checkOutput("doneReady", 32'(in_ready),  32'd1);
         checkOutput("doneAddr",  32'(imem_addr), 32'(modelAddr));
         checkOutput("doneCnt",   32'(word_cnt),  32'(modelCnt));
      end
   endtask

   initial begin
      logic [31:0] w1;
      logic [31:0] w2;
      logic [4:0]  rop;

      // Reset state while rst is held.
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rstReady", 32'(in_ready),  32'd1);
      checkOutput("rstWe",    32'(imem_we),   32'd0);
      checkOutput("rstAddr",  32'(imem_addr), 32'd0);
      checkOutput("rstWdata", imem_wdata,     32'd0);
      checkOutput("rstErr",   32'(err),       32'd0);
      checkOutput("rstCnt",   32'(word_cnt),  32'd0);
      @(negedge clk);
      rst = 1'b0;

      // ADD x3, x1, x2.
      applyStimulus(5'd2, 5'd3, 5'd1, 5'd2, 32'd0, w1, w2);
      checkOutput("planAdd", w1, 32'h002081B3);

      // SUB then ADDI back to back from a fresh reset.
      doReset();
      applyStimulus(5'd3, 5'd5, 5'd6, 5'd7, 32'd0, w1, w2);
      checkOutput("planSub", w1, 32'h407302B3);
      applyStimulus(5'd7, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, w1, w2);
      checkOutput("planAddi", w1, 32'hFFF00093);
      checkOutput("planCnt2", 32'(word_cnt), 32'd2);

      // Store, branch with negative offset, jump.
      applyStimulus(5'd1, 5'd0, 5'd1, 5'd2, 32'd8, w1, w2);
      checkOutput("planSw", w1, 32'h0020A423);
      applyStimulus(5'd11, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, w1, w2);
      checkOutput("planBeq", w1, 32'hFE208EE3);
      applyStimulus(5'd15, 5'd1, 5'd0, 5'd0, 32'd8, w1, w2);
      checkOutput("planJal", w1, 32'h008000EF);

      // LI with a low half that needs the +0x800 carry.
      applyStimulus(5'd18, 5'd5, 5'd0, 5'd0, 32'h12345FFF, w1, w2);
      checkOutput("planLiHi", w1, 32'h123462B7);
      checkOutput("planLiLo", w2, 32'hFFF28293);

      // Illegal op leaves address and count untouched.
      applyStimulus(5'd25, 5'd1, 5'd2, 5'd3, 32'd0, w1, w2);

      // Address wrap: five writes on a 16-byte port.
      doReset();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(5'd2, 5'(i), 5'd1, 5'd2, 32'd0, w1, w2);
      end
      checkOutput("wrapAddr", 32'(imem_addr), 32'd4);

      // addr_clr during the LI first word: word 1 at old address, word 2 at base.
      acceptInstr(5'd18, 5'd7, 5'd0, 5'd0, 32'h0000_0123);
      checkOutput("clrW1Addr", 32'(imem_addr), 32'(modelAddr));
      checkOutput("clrW1We",   32'(imem_we),   32'd1);
      addr_clr = 1'b1;
      @(posedge clk);
      #1;
      addr_clr = 1'b0;
      checkOutput("clrW2Addr", 32'(imem_addr), 32'd0);
      checkOutput("clrW2Data", imem_wdata,     refLiLow(5'd7, 32'h0000_0123));
      modelCnt  = modelCnt + 2;
      modelAddr = 4;
      @(posedge clk);
      #1;
      checkOutput("clrAfterAddr", 32'(imem_addr), 32'(modelAddr));
      checkOutput("clrAfterCnt",  32'(word_cnt),  32'(modelCnt));

      // Reset during the LI second word kills the strobe at once.
      acceptInstr(5'd18, 5'd9, 5'd0, 5'd0, 32'hDEAD_BEEF);
      checkOutput("rstLiW1", 32'(imem_we), 32'd1);
      @(posedge clk);
      #1;
      checkOutput("rstLiW2", 32'(imem_we), 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("midRstWe",    32'(imem_we),   32'd0);
      checkOutput("midRstAddr",  32'(imem_addr), 32'd0);
      checkOutput("midRstCnt",   32'(word_cnt),  32'd0);
      checkOutput("midRstReady", 32'(in_ready),  32'd1);
      @(negedge clk);
      rst = 1'b0;
      modelAddr = 0;
      modelCnt  = 0;
      @(posedge clk);
      #1;
      checkOutput("midRstNoLo", 32'(imem_we), 32'd0);

      // Random instructions, including some illegal codes.
      for (int i = 0; i < 40; i++) begin
         rop = 5'($urandom_range(0, 22));
         applyStimulus(rop, 5'($urandom), 5'($urandom), 5'($urandom),
                       $urandom, w1, w2);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
